// File: rtl/tdm_demux8.sv
// tdm_demux8: receive-side 1-to-8 TDM demultiplexer.
// A serial slot stream (one bit per valid beat, slot 0 marked by sof) is
// collected into a staging register and presented on dout as a complete
// 8-bit frame, with a one-cycle frame_vld pulse on the cycle dout changes.
//
// Handshake: din_vld is a pure qualifier with no back-pressure. A beat is
// consumed on every rising edge where din_vld=1; when din_vld=0, din and sof
// are ignored and all state holds, so gaps of any length are legal.
//
// The FSM has two states, HUNT and LOCKED. The locked output is a direct
// decode of the state register and serves as its debug view.
module tdm_demux8 #(
  parameter bit SOF_EVERY_FRAME = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_vld,
  input  logic       sof,
  output logic [7:0] dout,
  output logic       frame_vld,
  output logic [2:0] slot,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  // Slots 0..6 are staged; the slot-7 bit goes straight into dout so the
  // completed frame is visible one edge after the last bit is sampled.
  logic [6:0] stage_q, stage_d;
  logic [7:0] dout_q, dout_d;
  logic       frame_vld_q, frame_vld_d;
  logic       sync_err_q, sync_err_d;

  // Next-state and next-output logic for one consumed beat.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    stage_d     = stage_q;
    dout_d      = dout_q;
    frame_vld_d = 1'b0;
    sync_err_d  = 1'b0;

    if (din_vld) begin
      case (state_q)
        HUNT: begin
          // Bits before the first sof carry no frame position; drop them.
          if (sof) begin
            stage_d[0] = din;
            slot_d     = 3'd1;
            state_d    = LOCKED;
          end
        end

        LOCKED: begin
          if (slot_q == 3'd0) begin
            // Frame boundary: sof is either mandatory or only used to acquire.
            if (sof || !SOF_EVERY_FRAME) begin
              stage_d[0] = din;
              slot_d     = 3'd1;
            end else begin
              sync_err_d = 1'b1;
              state_d    = HUNT;
              slot_d     = 3'd0;
            end
          end else if (sof) begin
            // Early sof: drop the partial frame and restart at slot 0 in place.
            sync_err_d = 1'b1;
            stage_d[0] = din;
            slot_d     = 3'd1;
          end else if (slot_q == 3'd7) begin
            dout_d      = {din, stage_q};
            frame_vld_d = 1'b1;
            slot_d      = 3'd0;
          end else begin
            for (int i = 1; i < 7; i++) begin
              if (slot_q == 3'(i)) stage_d[i] = din;
            end
            slot_d = slot_q + 3'd1;
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 3'd0;
        end
      endcase
    end
  end

  // State and output registers; reset wins over any beat on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      slot_q      <= 3'd0;
      stage_q     <= 7'd0;
      dout_q      <= 8'h00;
      frame_vld_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      stage_q     <= stage_d;
      dout_q      <= dout_d;
      frame_vld_q <= frame_vld_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign dout      = dout_q;
  assign frame_vld = frame_vld_q;
  assign slot      = slot_q;
  assign locked    = (state_q == LOCKED);
  assign sync_err  = sync_err_q;

`ifndef SYNTHESIS
  // A completed frame and a framing error come from exclusive branches.
  a_pulse_excl: assert property (@(posedge clk) disable iff (rst)
    !(frame_vld_q && sync_err_q));
  // The slot counter only advances while locked.
  a_hunt_slot0: assert property (@(posedge clk) disable iff (rst)
    (state_q == HUNT) |-> (slot_q == 3'd0));
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed bench for tdm_demux8. Two instances share the
// input stream: u_dut_e requires sof every frame, u_dut_l only to lock.
module tb_tdm_demux8;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_vld;
  logic       sof;

  logic [7:0] dout_e, dout_l;
  logic       frame_vld_e, frame_vld_l;
  logic [2:0] slot_e, slot_l;
  logic       locked_e, locked_l;
  logic       sync_err_e, sync_err_l;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_dout;

  tdm_demux8 #(.SOF_EVERY_FRAME(1'b1)) u_dut_e (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
    .dout(dout_e), .frame_vld(frame_vld_e), .slot(slot_e),
    .locked(locked_e), .sync_err(sync_err_e)
  );

  tdm_demux8 #(.SOF_EVERY_FRAME(1'b0)) u_dut_l (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
    .dout(dout_l), .frame_vld(frame_vld_l), .slot(slot_l),
    .locked(locked_l), .sync_err(sync_err_l)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check all outputs of both instances against one expectation.
  task automatic check_outs(input string tag, input logic [7:0] d, input logic fv,
                            input logic [2:0] sl, input logic lk, input logic se);
    check_eq({tag, " e.dout"},      {24'd0, dout_e},      {24'd0, d});
    check_eq({tag, " e.frame_vld"}, {31'd0, frame_vld_e}, {31'd0, fv});
    check_eq({tag, " e.slot"},      {29'd0, slot_e},      {29'd0, sl});
    check_eq({tag, " e.locked"},    {31'd0, locked_e},    {31'd0, lk});
    check_eq({tag, " e.sync_err"},  {31'd0, sync_err_e},  {31'd0, se});
    check_eq({tag, " l.dout"},      {24'd0, dout_l},      {24'd0, d});
    check_eq({tag, " l.frame_vld"}, {31'd0, frame_vld_l}, {31'd0, fv});
    check_eq({tag, " l.slot"},      {29'd0, slot_l},      {29'd0, sl});
    check_eq({tag, " l.locked"},    {31'd0, locked_l},    {31'd0, lk});
    check_eq({tag, " l.sync_err"},  {31'd0, sync_err_l},  {31'd0, se});
  endtask

  // Drive one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick(input logic v, input logic d, input logic s);
    din_vld = v;
    din     = d;
    sof     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b1);   // beat during reset must be ignored
    check_outs("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    exp_dout = 8'h00;
  endtask

  // First n beats of a frame (sof on slot 0), no completion expected.
  task automatic send_partial(input string tag, input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b1, v[k], (k == 0));
      check_outs($sformatf("%s b%0d", tag, k), exp_dout, 1'b0, 3'(k + 1), 1'b1, 1'b0);
    end
  endtask

  // Full frame with sof on slot 0, optional idle gap before slot gap_slot,
  // and an optional sync_err expected on the first beat (early sof resync).
  task automatic send_frame(input string tag, input logic [7:0] v, input int gap_slot,
                            input int gap_len, input logic first_err);
    for (int k = 0; k < 8; k++) begin
      if (k == gap_slot) begin
        for (int g = 0; g < gap_len; g++) begin
          tick(1'b0, 1'b1, 1'b1);
          check_outs($sformatf("%s gap%0d", tag, g), exp_dout, 1'b0, 3'(k), 1'b1, 1'b0);
        end
      end
      tick(1'b1, v[k], (k == 0));
      if (k == 7) exp_dout = v;
      check_outs($sformatf("%s b%0d", tag, k), exp_dout, (k == 7), 3'((k + 1) % 8),
                 1'b1, (k == 0) && first_err);
    end
  endtask

  initial begin
    logic [7:0] v;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    din = 1'b0;
    din_vld = 1'b0;
    sof = 1'b0;
    exp_dout = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then bits 1,0,1,1,0,0,1,0 from slot 0 -> 8'h4D
    do_reset();
    send_frame("f4d", 8'h4D, 8, 0, 1'b0);

    // Bits with sof=0 while hunting are dropped, then a sof frame of 8'hFF
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      check_outs($sformatf("hunt b%0d", k), 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    send_frame("fff", 8'hFF, 8, 0, 1'b0);

    // Back-to-back A5 (3 idle beats at slot 4) then 3C
    send_frame("fa5", 8'hA5, 4, 3, 1'b0);
    send_frame("f3c", 8'h3C, 8, 0, 1'b0);

    // Early sof at slot 5 resyncs; the next 8 beats form 8'h96
    send_partial("pre96", 8'h1F, 5);
    send_frame("f96", 8'h96, 8, 0, 1'b1);

    // Missing sof on the next frame: strict instance drops lock,
    // lenient instance accepts the frame
    send_frame("f11", 8'h11, 8, 0, 1'b0);
    v = 8'h22;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, v[k], 1'b0);
      check_eq($sformatf("nosof b%0d e.sync_err", k),  {31'd0, sync_err_e},  {31'd0, (k == 0)});
      check_eq($sformatf("nosof b%0d e.frame_vld", k), {31'd0, frame_vld_e}, 32'd0);
      check_eq($sformatf("nosof b%0d e.locked", k),    {31'd0, locked_e},    32'd0);
      check_eq($sformatf("nosof b%0d e.slot", k),      {29'd0, slot_e},      32'd0);
      check_eq($sformatf("nosof b%0d e.dout", k),      {24'd0, dout_e},      32'h11);
      check_eq($sformatf("nosof b%0d l.sync_err", k),  {31'd0, sync_err_l},  32'd0);
      check_eq($sformatf("nosof b%0d l.frame_vld", k), {31'd0, frame_vld_l}, {31'd0, (k == 7)});
      check_eq($sformatf("nosof b%0d l.locked", k),    {31'd0, locked_l},    32'd1);
      check_eq($sformatf("nosof b%0d l.slot", k),      {29'd0, slot_l},      32'((k + 1) % 8));
      check_eq($sformatf("nosof b%0d l.dout", k),      {24'd0, dout_l},      (k == 7) ? 32'h22 : 32'h11);
    end

    // Reset pulsed at slot 3 of a frame discards it; no frame_vld afterwards
    do_reset();
    send_frame("fc3", 8'hC3, 8, 0, 1'b0);
    v = 8'h5A;
    send_partial("pre_rst", v, 3);
    rst = 1'b1;
    tick(1'b1, v[3], 1'b0);
    check_outs("midrst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    exp_dout = 8'h00;
    for (int k = 4; k < 8; k++) begin
      tick(1'b1, v[k], 1'b0);
      check_outs($sformatf("postrst b%0d", k), 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    send_frame("f5a", 8'h5A, 2, 1, 1'b0);

    tick(1'b0, 1'b0, 1'b0);
    check_outs("idle_end", 8'h5A, 1'b0, 3'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
